reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of the memory, peripheral and CPU reset domains.
// Reset sources are power-on (resetn), an external button, a watchdog pulse and
// a four-phase software request. The winning source is latched into cause_o.
// Optional feature: define RESET_DEBOUNCE_EN to debounce the button for
// DEBOUNCE_CYCLES consecutive high samples; without it the synchronized button
// level is used directly.
module reset_sequencer #(
    parameter int unsigned ASSERT_CYCLES   = 20,
    parameter int unsigned STAGE_GAP       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_i,
    input  logic       wdt_i,
    input  logic       sw_req_i,
    output logic       sw_ack_o,
    output logic       mem_reset_o,
    output logic       periph_reset_o,
    output logic       cpu_reset_o,
    output logic [1:0] cause_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        ST_ASSERT     = 3'd0,
        ST_REL_MEM    = 3'd1,
        ST_REL_PERIPH = 3'd2,
        ST_REL_CPU    = 3'd3,
        ST_RUN        = 3'd4
    } state_e;

    localparam logic [15:0] ASSERT_LAST = 16'(ASSERT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(STAGE_GAP - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;
    localparam logic [1:0] CAUSE_SW  = 2'b11;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_q, mem_d;
    logic        periph_q, periph_d;
    logic        cpu_q, cpu_d;
    logic [1:0]  cause_q, cause_d;
    logic        ack_q, ack_d;
    logic        armed_q, armed_d;

    logic        btn_meta_q, btn_sync_q;
    logic        btn_qual;
    logic        hw_req;
    logic        legal_state;
    logic        hw_acc;
    logic        sw_acc;
    logic        req_acc;
    logic [1:0]  req_cause;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_i;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef RESET_DEBOUNCE_EN
    localparam logic [15:0] DEB_TARGET = 16'(DEBOUNCE_CYCLES);

    logic [15:0] deb_cnt_q, deb_cnt_d;

    // Count consecutive high samples, saturating at the target; any low clears
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (!btn_sync_q) begin
            deb_cnt_d = 16'd0;
        end else if (deb_cnt_q != DEB_TARGET) begin
            deb_cnt_d = deb_cnt_q + 16'd1;
        end
    end

    // Debounce counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            deb_cnt_q <= 16'd0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_qual = (deb_cnt_q == DEB_TARGET);
`else
    // Debounce length has no meaning when the synchronized level is used as-is
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES == 0);
    assign btn_qual        = btn_sync_q;
`endif

    // Button and watchdog restart the sequence from any of the normal states.
    // Software requests are only taken in RUN: a pending request that lost
    // priority waits for the sequence to finish instead of restarting it.
    assign hw_req      = btn_qual | wdt_i;
    assign legal_state = (state_q == ST_ASSERT) || (state_q == ST_REL_MEM) ||
                         (state_q == ST_REL_PERIPH) || (state_q == ST_RUN);
    assign hw_acc      = hw_req & legal_state;
    assign sw_acc      = (state_q == ST_RUN) & sw_req_i & armed_q & ~hw_req;
    assign req_acc     = hw_acc | sw_acc;
    assign req_cause   = btn_qual ? CAUSE_BTN : (wdt_i ? CAUSE_WDT : CAUSE_SW);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ASSERT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (req_acc) begin
            state_d = ST_ASSERT;
        end else begin
            case (state_q)
                ST_ASSERT:     if (cnt_q == ASSERT_LAST) state_d = ST_REL_MEM;
                ST_REL_MEM:    if (cnt_q == GAP_LAST)    state_d = ST_REL_PERIPH;
                ST_REL_PERIPH: if (cnt_q == GAP_LAST)    state_d = ST_RUN;
                ST_RUN:        state_d = ST_RUN;
                // REL_CPU is never targeted; it and any corrupt encoding recover
                default:       state_d = ST_ASSERT;
            endcase
        end
    end

    // Output logic: counter, domain resets, cause, handshake next values
    always_comb begin
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        periph_d = periph_q;
        cpu_d    = cpu_q;
        cause_d  = cause_q;
        ack_d    = 1'b0;
        // Re-arm once the requester has dropped its level
        armed_d  = sw_acc ? 1'b0 : (sw_req_i ? armed_q : 1'b1);

        if (req_acc) begin
            cnt_d    = 16'd0;
            mem_d    = 1'b1;
            periph_d = 1'b1;
            cpu_d    = 1'b1;
            cause_d  = req_cause;
            ack_d    = sw_acc;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    mem_d    = 1'b1;
                    periph_d = 1'b1;
                    cpu_d    = 1'b1;
                    if (cnt_q == ASSERT_LAST) begin
                        cnt_d = 16'd0;
                        mem_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_REL_MEM: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d    = 16'd0;
                        periph_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_REL_PERIPH: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = 16'd0;
                        cpu_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    cnt_d    = 16'd0;
                    mem_d    = 1'b1;
                    periph_d = 1'b1;
                    cpu_d    = 1'b1;
                end
            endcase
        end
    end

    // Datapath registers; cause survives everything except resetn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= 16'd0;
            mem_q    <= 1'b1;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            cause_q  <= CAUSE_POR;
            ack_q    <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            cause_q  <= cause_d;
            ack_q    <= ack_d;
            armed_q  <= armed_d;
        end
    end

    assign mem_reset_o    = mem_q;
    assign periph_reset_o = periph_q;
    assign cpu_reset_o    = cpu_q;
    assign cause_o        = cause_q;
    assign sw_ack_o       = ack_q;
    assign busy_o         = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: table of directed vectors, hand-written
// multi-cycle sequences, then randomized traffic against a timeline model.
module tb_reset_sequencer;

    localparam int AC = 20;
    localparam int SG = 4;
    localparam int DB = 8;
`ifdef RESET_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       btn_i = 1'b0;
    logic       wdt_i = 1'b0;
    logic       sw_req_i = 1'b0;
    logic       sw_ack_o;
    logic       mem_reset_o;
    logic       periph_reset_o;
    logic       cpu_reset_o;
    logic [1:0] cause_o;
    logic       busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .ASSERT_CYCLES  (AC),
        .STAGE_GAP      (SG),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .btn_i         (btn_i),
        .wdt_i         (wdt_i),
        .sw_req_i      (sw_req_i),
        .sw_ack_o      (sw_ack_o),
        .mem_reset_o   (mem_reset_o),
        .periph_reset_o(periph_reset_o),
        .cpu_reset_o   (cpu_reset_o),
        .cause_o       (cause_o),
        .busy_o        (busy_o)
    );

    // Reference model: elapsed edges since the last sequence start, plus
    // cause, handshake and button-qualification history.
    int         m_t;
    int         m_run;
    logic [1:0] m_cause;
    bit         m_armed, m_ack, m_s1, m_s2;

    function automatic logic [6:0] e(bit m, bit p, bit c, bit b, logic [1:0] ca, bit a);
        return {m, p, c, b, ca, a};
    endfunction

    function automatic logic [6:0] model_exp();
        return e(m_t < AC, m_t < AC + SG, m_t < AC + 2*SG, m_t < AC + 2*SG, m_cause, m_ack);
    endfunction

    task automatic model_reset();
        m_t = 0; m_run = 0; m_cause = 2'b00;
        m_armed = 1'b1; m_ack = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge(input bit b, input bit w, input bit s);
        bit bq, inrun, hw, swacc;
        int nrun;
        bq    = DEB ? (m_run >= DB) : m_s2;
        inrun = (m_t >= AC + 2*SG);
        hw    = bq | w;
        swacc = inrun & s & m_armed & !hw;
        nrun  = m_s2 ? ((m_run < DB) ? m_run + 1 : m_run) : 0;
        if (hw || swacc) begin
            m_t     = 0;
            m_cause = bq ? 2'b01 : (w ? 2'b10 : 2'b11);
            m_ack   = swacc;
        end else begin
            m_ack = 1'b0;
            if (!inrun) m_t = m_t + 1;
        end
        m_armed = swacc ? 1'b0 : (!s ? 1'b1 : m_armed);
        m_s2 = m_s1;
        m_s1 = b;
        m_run = nrun;
    endtask

    task automatic chk(input string nm, input logic [6:0] exp);
        logic [6:0] got;
        got = {mem_reset_o, periph_reset_o, cpu_reset_o, busy_o, cause_o, sw_ack_o};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {mem,per,cpu,busy,cause,ack}=%b required %b (t=%0t)",
                      nm, got, exp, $time);
    endtask

    // Called at a falling edge: drive inputs, advance the model, clock once
    task automatic step(input bit b, input bit w, input bit s);
        btn_i = b; wdt_i = w; sw_req_i = s;
        model_edge(b, w, s);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string nm);
        resetn = 1'b0;
        model_reset();
        #1;
        chk(nm, e(1, 1, 1, 1, 2'b00, 0));
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        string      name;
        bit         btn, wdt, sw;
        int         cycles;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t v(string nm, bit b, bit w, bit s, int n, logic [6:0] x);
        vec_t r;
        r.name = nm; r.btn = b; r.wdt = w; r.sw = s; r.cycles = n; r.exp = x;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        tbl.push_back(v("por_t19",       0, 0, 0, 19, e(1, 1, 1, 1, 2'b00, 0)));
        tbl.push_back(v("por_mem_rel",   0, 0, 0,  1, e(0, 1, 1, 1, 2'b00, 0)));
        tbl.push_back(v("por_t23",       0, 0, 0,  3, e(0, 1, 1, 1, 2'b00, 0)));
        tbl.push_back(v("por_per_rel",   0, 0, 0,  1, e(0, 0, 1, 1, 2'b00, 0)));
        tbl.push_back(v("por_run",       0, 0, 0,  4, e(0, 0, 0, 0, 2'b00, 0)));
        tbl.push_back(v("wdt_hit",       0, 1, 0,  1, e(1, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt_t19",       0, 0, 0, 19, e(1, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt_mem_rel",   0, 0, 0,  1, e(0, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt_run",       0, 0, 0,  8, e(0, 0, 0, 0, 2'b10, 0)));
        tbl.push_back(v("sw_accept",     0, 0, 1,  1, e(1, 1, 1, 1, 2'b11, 1)));
        tbl.push_back(v("sw_ack_1cyc",   0, 0, 1,  1, e(1, 1, 1, 1, 2'b11, 0)));
        tbl.push_back(v("sw_held_run",   0, 0, 1, 27, e(0, 0, 0, 0, 2'b11, 0)));
        tbl.push_back(v("sw_no_repeat",  0, 0, 1,  3, e(0, 0, 0, 0, 2'b11, 0)));
        tbl.push_back(v("sw_drop",       0, 0, 0,  1, e(0, 0, 0, 0, 2'b11, 0)));
        tbl.push_back(v("sw_second",     0, 0, 1,  1, e(1, 1, 1, 1, 2'b11, 1)));
        tbl.push_back(v("wdt_over_sw",   0, 1, 1,  1, e(1, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt2_run",      0, 0, 0, 28, e(0, 0, 0, 0, 2'b10, 0)));
        tbl.push_back(v("wdt3_hit",      0, 1, 0,  1, e(1, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt3_t22",      0, 0, 0, 22, e(0, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt_in_relmem", 0, 1, 0,  1, e(1, 1, 1, 1, 2'b10, 0)));
        tbl.push_back(v("wdt4_run",      0, 0, 0, 28, e(0, 0, 0, 0, 2'b10, 0)));

        @(negedge clk);
        do_reset("reset_state");

        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].cycles; i++) step(tbl[k].btn, tbl[k].wdt, tbl[k].sw);
            chk(tbl[k].name, tbl[k].exp);
        end

        // Abort during REL_PERIPH, then a full power-on sequence again
        step(0, 1, 0);
        idle(25);
        chk("abort_pre", e(0, 0, 1, 1, 2'b10, 0));
        do_reset("abort_async");
        idle(20);
        chk("abort_mem", e(0, 1, 1, 1, 2'b00, 0));
        idle(4);
        chk("abort_per", e(0, 0, 1, 1, 2'b00, 0));
        idle(4);
        chk("abort_run", e(0, 0, 0, 0, 2'b00, 0));

        // Button, watchdog and software all qualify on the same edge
        if (DEB) begin
            for (int i = 0; i < DB; i++) step(1, 0, 0);
            idle(2);
        end else begin
            step(1, 0, 0);
            idle(1);
        end
        chk("simul_pre", e(0, 0, 0, 0, 2'b00, 0));
        step(0, 1, 1);
        chk("simul_btn_wins", e(1, 1, 1, 1, 2'b01, 0));
        for (int i = 0; i < 28; i++) step(0, 0, 1);
        chk("simul_sw_pending", e(0, 0, 0, 0, 2'b01, 0));
        step(0, 0, 1);
        chk("simul_sw_taken", e(1, 1, 1, 1, 2'b11, 1));
        idle(28);
        chk("simul_run", e(0, 0, 0, 0, 2'b11, 0));

        // Button qualification
        if (DEB) begin
            for (int i = 0; i < DB - 1; i++) step(1, 0, 0);
            idle(12);
            chk("btn_short_ignored", e(0, 0, 0, 0, 2'b11, 0));
            for (int i = 0; i < DB; i++) step(1, 0, 0);
            idle(3);
            chk("btn_debounced", e(1, 1, 1, 1, 2'b01, 0));
            idle(28);
            chk("btn_run", e(0, 0, 0, 0, 2'b01, 0));
        end else begin
            for (int i = 0; i < 3; i++) step(1, 0, 0);
            idle(2);
            chk("btn_pulse", e(1, 1, 1, 1, 2'b01, 0));
            idle(27);
            chk("btn_hold_cnt", e(0, 0, 1, 1, 2'b01, 0));
            idle(1);
            chk("btn_run", e(0, 0, 0, 0, 2'b01, 0));
        end

        // Randomized traffic against the model
        do_reset("rand_reset");
        begin
            bit b, s;
            b = 1'b0; s = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset("rand_async_reset");
                end
                if (b) b = ($urandom_range(0, 7) != 0);
                else   b = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 9) == 0) s = ~s;
                step(b, $urandom_range(0, 79) == 0, s);
                chk("rand_model", model_exp());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
